// File: rtl/matmul_job_scheduler_pkg.sv
// Shared types and packing helpers for the matmul job scheduler: FSM state
// encoding, element widths/count and flattened-matrix bit offsets.
package matmul_job_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int AB_W      = 8;
    localparam int C_W       = 16;
    localparam int N_ELEM    = 9;
    localparam int AB_FLAT_W = AB_W * N_ELEM;
    localparam int C_FLAT_W  = C_W * N_ELEM;

    // Element k of a row-major flattened matrix sits at [lo+W-1:lo].
    function automatic int ab_lo(input int k);
        return AB_W * k;
    endfunction

    function automatic int c_lo(input int k);
        return C_W * k;
    endfunction

endpackage

// File: rtl/matmul_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational pick plus a registered one-cycle
// grant pulse; on a tie the requester that did not win last time is chosen.
module matmul_rr_arbiter2
    import matmul_job_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       win_valid,
    output logic       win_idx
);

    logic last_grant_q;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        win_valid = |req;
        win_idx   = 1'b0;
        case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_grant_q;
            default: win_idx = 1'b0;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            gnt          <= 2'b00;
        end else if (en && win_valid) begin
            last_grant_q <= win_idx;
            gnt          <= 2'b01 << win_idx;
        end else begin
            gnt          <= 2'b00;
        end
    end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Shares one serial 3x3 matrix multiplier between two requesters: grant,
// latch operands, pulse the multiplier reset, run, and hand back C.
module matmul_job_scheduler
    import matmul_job_scheduler_pkg::*;
#(
    parameter int RST_PULSE      = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CW             = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [AB_FLAT_W-1:0]   req_a0,
    input  logic [AB_FLAT_W-1:0]   req_a1,
    input  logic [AB_FLAT_W-1:0]   req_b0,
    input  logic [AB_FLAT_W-1:0]   req_b1,
    output logic [1:0]             gnt,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [N_ELEM*CW-1:0]   rsp_c,
    output logic                   rsp_err,
    output logic [CW-1:0]          rsp_cycles,
    output logic                   busy,
    output logic                   mult_rst,
    output logic [AB_FLAT_W-1:0]   mult_a,
    output logic [AB_FLAT_W-1:0]   mult_b,
    input  logic [N_ELEM*CW-1:0]   mult_c,
    input  logic                   mult_done
);

    localparam logic [3:0]    RST_LAST = 4'(RST_PULSE - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_VAL  = CW'(TIMEOUT_CYCLES);

    state_t        state_q, next_state;
    logic          owner_q;
    logic [3:0]    clr_cnt_q;
    logic [CW-1:0] run_cnt_q;
    logic [CW-1:0] tmo_cnt_q;
    logic          win_valid, win_idx;
    logic          run_ok, run_tmo;
    logic          busy_d, mult_rst_d;
    logic [1:0]    rsp_valid_d;

    matmul_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == ST_IDLE),
        .req       (req),
        .gnt       (gnt),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    // A done flag takes priority over a timeout landing on the same cycle.
    assign run_ok  = mult_done;
    assign run_tmo = !mult_done && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE:  if (win_valid)                 next_state = ST_CLEAR;
            ST_CLEAR: if (clr_cnt_q == RST_LAST)     next_state = ST_RUN;
            ST_RUN:   if (run_ok || run_tmo)         next_state = ST_RESP;
            ST_RESP:  if (rsp_ready[owner_q])        next_state = ST_IDLE;
            default:                                 next_state = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from next_state so they line up with it.
    always_comb begin
        busy_d      = (next_state != ST_IDLE);
        mult_rst_d  = (next_state == ST_IDLE) || (next_state == ST_CLEAR);
        rsp_valid_d = rsp_valid;
        if (state_q == ST_RUN && next_state == ST_RESP)
            rsp_valid_d = 2'b01 << owner_q;
        else if (state_q == ST_RESP && next_state == ST_IDLE)
            rsp_valid_d = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            mult_rst   <= 1'b1;
            rsp_valid  <= 2'b00;
            rsp_c      <= '0;
            rsp_err    <= 1'b0;
            rsp_cycles <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            owner_q    <= 1'b0;
            clr_cnt_q  <= '0;
            run_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            busy      <= busy_d;
            mult_rst  <= mult_rst_d;
            rsp_valid <= rsp_valid_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        mult_a    <= win_idx ? req_a1 : req_a0;
                        mult_b    <= win_idx ? req_b1 : req_b0;
                        owner_q   <= win_idx;
                        clr_cnt_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 4'd1;
                    if (clr_cnt_q == RST_LAST) begin
                        run_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (run_ok) begin
                        rsp_c      <= mult_c;
                        rsp_cycles <= run_cnt_q;
                        rsp_err    <= 1'b0;
                    end else if (run_tmo) begin
                        rsp_c      <= '0;
                        rsp_cycles <= TMO_VAL;
                        rsp_err    <= 1'b1;
                    end else begin
                        run_cnt_q <= (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/matmul_job_scheduler.md
Name: matmul_job_scheduler

Overview:
- Shares one serial 3x3 8-bit matrix multiplier (36-step FSM, done flag held high, restarted only by its active-high reset) between two requesters.
- For each job: arbitrates round-robin, latches the operands, pulses the multiplier reset, waits for done and captures C.
- Returns C to the winning requester with a valid/ready handshake, plus the measured run length and a timeout error.

Parameters:
- RST_PULSE, 2, cycles mult_rst is held high per job (1..15)
- TIMEOUT_CYCLES, 64, RUN cycles without mult_done before the job is aborted
- CW, 16, width of each C element and of the cycle counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  per-requester job request (level)
- req_a0, req_a1  in  72 each  requester matrix A, flattened, element k at [8k+7:8k], row-major
- req_b0, req_b1  in  72 each  requester matrix B, same packing
- gnt  out  2  one-cycle grant; operands latched on that edge
- rsp_valid  out  2  per-requester result valid
- rsp_ready  in  2  per-requester result accept
- rsp_c  out  144  result C, element k at [16k+15:16k]
- rsp_err  out  1  job aborted by timeout (rsp_c is zero)
- rsp_cycles  out  16  RUN-cycle count of the returned job
- busy  out  1  high in every state except IDLE
- mult_rst  out  1  drives the multiplier's active-high reset
- mult_a, mult_b  out  72 each  latched operands to the multiplier
- mult_c  in  144  multiplier outputs c0..c8, same packing as rsp_c
- mult_done  in  1  multiplier done flag

Behaviour:
- Reset values (async, rst_n low): state IDLE; gnt=0; rsp_valid=0; rsp_c=0; rsp_err=0; rsp_cycles=0; busy=0; mult_a=0; mult_b=0; last_grant=1, so requester 0 wins first.
- mult_rst resets to 1 and stays 1 while IDLE, keeping the multiplier parked.
- All outputs are registered.
- States: IDLE -> CLEAR -> RUN -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, grant one: the single requester if only one; the requester not equal to last_grant if both.
  - Set gnt[i]=1 for one cycle, latch req_ai/req_bi into mult_a/mult_b, record the job owner, update last_grant, go to CLEAR.
- CLEAR:
  - mult_rst=1 for RST_PULSE cycles, then deassert it registered and enter RUN.
  - On RUN entry, clear the run counter and the timeout counter.
- RUN:
  - Each cycle with mult_done=0, increment the run counter (saturating at 0xFFFF).
  - When mult_done=1: capture mult_c into rsp_c, set rsp_cycles=run counter, rsp_err=0, set rsp_valid[owner]=1, go to RESP.
  - With the standard multiplier, rsp_cycles = 37.
  - If the run counter reaches TIMEOUT_CYCLES without done: rsp_c=0, rsp_err=1, rsp_cycles=TIMEOUT_CYCLES, set rsp_valid[owner], go to RESP.
- RESP:
  - rsp_valid[owner], rsp_c, rsp_err and rsp_cycles stay stable until rsp_ready[owner]=1 on a clock edge.
  - On that edge: clear rsp_valid, drive mult_rst=1 and return to IDLE.
  - rsp_ready on the non-owner bit is ignored.
  - A ready bit already high when valid rises completes the transfer on the next edge (one cycle of valid).
- Requests arriving while busy stay pending; a requester holds req until it sees gnt.
- A req still high on the edge after its own gnt starts a new job.
- In RESP the grant for the next job is issued at the earliest in the IDLE cycle after the handshake; no overlap.
- Arithmetic: no widening or saturation of C. The multiplier's 16-bit wrap passes through unchanged.
- Reset mid-job: everything returns to the reset values immediately; any in-flight result is discarded; mult_rst goes high asynchronously.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, CLEAR, RUN, RESP)
  - element widths 8/16 and element count 9
  - packing offset functions for A/B/C
- One natural sub-module: matmul_rr_arbiter2 (2-way round-robin with last_grant register and grant pulse).
- FSM, counters and operand/result registers stay in the top module.

Test Plan:
- req=01, A=1..9, B=identity; rsp_ready held 1 -> gnt=01 once; C=1..9; rsp_valid[0] high for exactly 1 cycle; rsp_err=0; rsp_cycles=37.
- req=11 simultaneously after reset, A0=B0=identity, A1=all 2, B1=all 3 -> requester 0 is served first with C=identity; then requester 1 with every C element 18; gnt order 01 then 10.
- A=B=all 255 -> every C element 64003 (195075 mod 65536); rsp_err=0.
- Stubbed multiplier with mult_done stuck 0 -> after 64 RUN cycles rsp_err=1, rsp_c=0, rsp_cycles=64, valid to the owner; the next job completes normally.
- rsp_ready[owner] held low for 20 cycles with rsp_ready[other]=1 -> rsp_valid and rsp_c remain stable and busy=1; no new gnt until owner ready.
- rst_n pulsed low during RUN -> all outputs at reset values in the same cycle, mult_rst=1; the pending req=10 is granted first after release.
